// File: rtl/scatter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scatter_pkg
// Description : Shared definitions for the scatter block. Holds the state
//               encoding and the tag-index width rule. The tagged word layout
//               is {index, data}, with the index in the MSBs. The gather side
//               uses the same layout, so both ends agree on it.
// Revision    : 1.0  initial release
// ============================================================================
package scatter_pkg;

    // Frame state: collecting words, or releasing them to the output ports.
    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } scatter_state_t;

    // Width of the index field for a frame of n words. It is never narrower
    // than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : scatter_pkg
`default_nettype wire

// File: rtl/scatter_demultiplex.sv
`default_nettype none
// ============================================================================
// Module      : scatter_demultiplex
// Description : Splits a tagged {index, data} word. Decodes the index into a
//               one-hot slot select and flags whether the index addresses a
//               real slot. This is the counterpart of the gather-side
//               multiplex.
// Revision    : 1.0  initial release
// ============================================================================
module scatter_demultiplex
    import scatter_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 2,
    localparam int AW = idx_width(N)
) (
    input  logic [AW+W-1:0] word,
    output logic [W-1:0]    data,
    output logic [N-1:0]    sel,
    output logic            in_range
);

    logic [AW-1:0] w_idx;

    assign w_idx = word[AW+W-1 -: AW];
    assign data  = word[W-1:0];

    // Indices past the last slot can only occur when N is not a power of two.
    // For those indices the select stays all-zero and in_range is low.
    assign in_range = (32'(w_idx) < 32'(N));

    // One decoder output per slot.
    generate
        for (genvar i = 0; i < N; i++) begin : g_sel
            localparam logic [AW-1:0] c_idx = AW'(i);
            assign sel[i] = (w_idx == c_idx);
        end
    endgenerate

endmodule : scatter_demultiplex
`default_nettype wire

// File: rtl/scatter.sv
`default_nettype none
// ============================================================================
// Module      : scatter
// Description : Collects one frame of N tagged words. Each word lands in the
//               slot named by its index, in any arrival order. When the frame
//               is complete, all N ports are released at once. Each port then
//               drains on its own handshake. No new word is accepted until
//               every port has drained.
// Revision    : 1.0  initial release
// ============================================================================
module scatter
    import scatter_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 2,
    localparam int AW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_stb,
    input  logic [AW+W-1:0] s_dat,
    output logic            s_rdy,
    output logic [N-1:0]    m_stb,
    output logic [N*W-1:0]  m_dat,
    input  logic [N-1:0]    m_rdy
);

    scatter_state_t r_state;
    logic [N-1:0]   r_full;
    logic [N-1:0]   r_pend;
    logic [W-1:0]   r_slot [N];

    logic [W-1:0]   w_data;
    logic [N-1:0]   w_sel;
    logic           w_in_range;
    logic           w_slot_taken;
    logic           w_accept;
    logic [N-1:0]   w_fill_we;
    logic [N-1:0]   w_full_fill;
    logic [N-1:0]   w_hs;
    logic [N-1:0]   w_pend_drain;

    scatter_demultiplex #(
        .W (W),
        .N (N)
    ) u_demux (
        .word     (s_dat),
        .data     (w_data),
        .sel      (w_sel),
        .in_range (w_in_range)
    );

    // The slot addressed by the incoming word already holds a word for this
    // frame. A duplicate index therefore waits for the next frame.
    assign w_slot_taken = |(w_sel & r_full);

    // Out-of-range words are always taken and then dropped. In-range words
    // are taken only while their slot is still empty.
    assign s_rdy = (r_state == ST_FILL) && (!w_in_range || !w_slot_taken);

    assign w_accept    = s_stb && s_rdy;
    assign w_fill_we   = (w_accept && w_in_range) ? w_sel : '0;
    assign w_full_fill = r_full | w_fill_we;

    // Per-port handshakes. pend is zero outside DRAIN, so these are inert
    // during FILL.
    assign w_hs         = r_pend & m_rdy;
    assign w_pend_drain = r_pend & ~w_hs;

    // Frame FSM with the full/pend bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FILL;
            r_full  <= '0;
            r_pend  <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    r_full <= w_full_fill;
                    // Release on the same edge that accepts the last word.
                    if (&w_full_fill) begin
                        r_state <= ST_DRAIN;
                        r_pend  <= '1;
                    end
                end
                ST_DRAIN: begin
                    r_pend <= w_pend_drain;
                    r_full <= r_full & ~w_hs;
                    // Return to FILL on the edge where the last ports finish.
                    if (w_pend_drain == '0) begin
                        r_state <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    // Slot storage. Each slot holds its value until the next frame
    // overwrites it.
    generate
        for (genvar i = 0; i < N; i++) begin : g_slot
            // Capture the word addressed to this slot.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_slot[i] <= '0;
                end else if (w_fill_we[i]) begin
                    r_slot[i] <= w_data;
                end
            end

            assign m_dat[i*W +: W] = r_slot[i];
        end
    endgenerate

    assign m_stb = r_pend;

endmodule : scatter
`default_nettype wire

// File: tb/tb_scatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scatter
// Description : Self-checking bench for scatter. Directed frame scenarios
//               run on an N=4 instance and an N=3 instance. A randomized
//               run is compared against a frame-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scatter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic             s_stb;
    logic [AW+W-1:0]  s_dat;
    logic             s_rdy;
    logic [N-1:0]     m_stb;
    logic [N*W-1:0]   m_dat;
    logic [N-1:0]     m_rdy;

    logic             s_stb3;
    logic [AW+W-1:0]  s_dat3;
    logic             s_rdy3;
    logic [N3-1:0]    m_stb3;
    logic [N3*W-1:0]  m_dat3;
    logic [N3-1:0]    m_rdy3;

    int n_pass  = 0;
    int n_total = 0;

    scatter #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat),
        .m_rdy (m_rdy)
    );

    scatter #(.W(W), .N(N3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .s_stb (s_stb3),
        .s_dat (s_dat3),
        .s_rdy (s_rdy3),
        .m_stb (m_stb3),
        .m_dat (m_dat3),
        .m_rdy (m_rdy3)
    );

    // ---------------------------------------------------------------------
    // Reference model: the set of indices seen in this frame, their values,
    // and which ports are still owed a handshake.
    // ---------------------------------------------------------------------
    bit           md_fill;
    bit           md_have [N];
    logic [W-1:0] md_val  [N];
    bit           md_pend [N];

    function automatic void model_reset();
        md_fill = 1'b1;
        for (int i = 0; i < N; i++) begin
            md_have[i] = 1'b0;
            md_val[i]  = '0;
            md_pend[i] = 1'b0;
        end
    endfunction

    function automatic bit exp_rdy();
        int idx;
        idx = int'(s_dat[AW+W-1:W]);
        if (!md_fill) return 1'b0;
        if (idx >= N) return 1'b1;
        return !md_have[idx];
    endfunction

    function automatic logic [N-1:0] exp_stb();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = md_pend[i];
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_dat();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = md_val[i];
        return r;
    endfunction

    // Advance the model by one clock edge, using the inputs the bench drove.
    function automatic void model_edge();
        int idx;
        int cnt;
        int left;
        if (md_fill) begin
            idx = int'(s_dat[AW+W-1:W]);
            if (s_stb && exp_rdy() && idx < N) begin
                md_have[idx] = 1'b1;
                md_val[idx]  = s_dat[W-1:0];
            end
            cnt = 0;
            for (int i = 0; i < N; i++) cnt += int'(md_have[i]);
            if (cnt == N) begin
                md_fill = 1'b0;
                for (int i = 0; i < N; i++) md_pend[i] = 1'b1;
            end
        end else begin
            left = 0;
            for (int i = 0; i < N; i++) begin
                if (md_pend[i] && m_rdy[i]) begin
                    md_pend[i] = 1'b0;
                    md_have[i] = 1'b0;
                end
                if (md_pend[i]) left++;
            end
            if (left == 0) md_fill = 1'b1;
        end
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push a whole in-order frame of base+i into the N=4 instance.
    task automatic fill_frame(input logic [7:0] base);
        for (int i = 0; i < N; i++) begin
            s_stb = 1'b1;
            s_dat = {2'(i), base + 8'(i)};
            tick();
        end
        s_stb = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst    = 1'b0;
        s_stb  = 1'b0; s_dat  = '0; m_rdy  = '0;
        s_stb3 = 1'b0; s_dat3 = '0; m_rdy3 = '0;
        #12;
        n_total++;
        if (m_stb !== 4'b0000) $display("FAIL reset_m_stb: got %b expected %b", m_stb, 4'b0000);
        else n_pass++;
        n_total++;
        if (m_dat !== 32'h0) $display("FAIL reset_m_dat: got %h expected %h", m_dat, 32'h0);
        else n_pass++;
        n_total++;
        if (m_stb3 !== 3'b000) $display("FAIL reset_m_stb3: got %b expected %b", m_stb3, 3'b000);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (s_rdy !== 1'b1) $display("FAIL reset_s_rdy: got %b expected %b", s_rdy, 1'b1);
        else n_pass++;
        tick();
    endtask

    task automatic test_in_order();
        m_rdy = 4'b1111;
        for (int i = 0; i < N; i++) begin
            s_stb = 1'b1;
            s_dat = {2'(i), 8'h10 + 8'(i)};
            #1;
            n_total++;
            if (s_rdy !== 1'b1) $display("FAIL in_order_s_rdy[%0d]: got %b expected 1", i, s_rdy);
            else n_pass++;
            n_total++;
            if (m_stb !== 4'b0000) $display("FAIL in_order_no_early_stb[%0d]: got %b expected 0000", i, m_stb);
            else n_pass++;
            tick();
        end
        s_stb = 1'b0;
        n_total++;
        if (m_stb !== 4'b1111) $display("FAIL in_order_release: got %b expected 1111", m_stb);
        else n_pass++;
        n_total++;
        if (m_dat !== 32'h13121110) $display("FAIL in_order_m_dat: got %h expected 13121110", m_dat);
        else n_pass++;
        tick();
        n_total++;
        if (m_stb !== 4'b0000) $display("FAIL in_order_drained: got %b expected 0000", m_stb);
        else n_pass++;
        tick();
        n_total++;
        if (s_rdy !== 1'b1) $display("FAIL in_order_refill_rdy: got %b expected 1", s_rdy);
        else n_pass++;
        m_rdy = 4'b0000;
    endtask

    task automatic test_dup();
        m_rdy = 4'b0000;
        s_stb = 1'b1; s_dat = {2'd2, 8'h22}; tick();
        s_dat = {2'd0, 8'h20}; tick();
        s_dat = {2'd2, 8'hAA};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (s_rdy !== 1'b0) $display("FAIL dup_stall[%0d]: got %b expected 0", k, s_rdy);
            else n_pass++;
            tick();
        end
        s_dat = {2'd3, 8'h33}; tick();
        s_dat = {2'd1, 8'h11}; tick();
        s_stb = 1'b0;
        n_total++;
        if (m_stb !== 4'b1111) $display("FAIL dup_release: got %b expected 1111", m_stb);
        else n_pass++;
        n_total++;
        if (m_dat !== 32'h33221120) $display("FAIL dup_m_dat: got %h expected 33221120", m_dat);
        else n_pass++;
        m_rdy = 4'b1111; tick(); m_rdy = 4'b0000;
        n_total++;
        if (m_stb !== 4'b0000) $display("FAIL dup_drained: got %b expected 0000", m_stb);
        else n_pass++;
        s_stb = 1'b1; s_dat = {2'd2, 8'hAA};
        #1;
        n_total++;
        if (s_rdy !== 1'b1) $display("FAIL dup_next_frame_rdy: got %b expected 1", s_rdy);
        else n_pass++;
        tick();
        s_dat = {2'd0, 8'hA0}; tick();
        s_dat = {2'd1, 8'hA1}; tick();
        s_dat = {2'd3, 8'hA3}; tick();
        s_stb = 1'b0;
        n_total++;
        if (m_dat !== 32'hA3AAA1A0) $display("FAIL dup_next_frame_dat: got %h expected A3AAA1A0", m_dat);
        else n_pass++;
        m_rdy = 4'b1111; tick(); m_rdy = 4'b0000;
    endtask

    task automatic test_independent_drain();
        m_rdy = 4'b0000;
        fill_frame(8'h40);
        n_total++;
        if (m_stb !== 4'b1111) $display("FAIL indep_release: got %b expected 1111", m_stb);
        else n_pass++;
        m_rdy = 4'b0001; tick(); m_rdy = 4'b0000;
        n_total++;
        if (m_stb !== 4'b1110) $display("FAIL indep_step1: got %b expected 1110", m_stb);
        else n_pass++;
        s_stb = 1'b1; s_dat = {2'd0, 8'h5A};
        #1;
        n_total++;
        if (s_rdy !== 1'b0) $display("FAIL indep_no_rdy: got %b expected 0", s_rdy);
        else n_pass++;
        s_stb = 1'b0;
        m_rdy = 4'b1000; tick(); m_rdy = 4'b0000;
        n_total++;
        if (m_stb !== 4'b0110) $display("FAIL indep_step2: got %b expected 0110", m_stb);
        else n_pass++;
        n_total++;
        if (m_dat !== 32'h43424140) $display("FAIL indep_dat_stable: got %h expected 43424140", m_dat);
        else n_pass++;
        m_rdy = 4'b0110; tick(); m_rdy = 4'b0000;
        n_total++;
        if (m_stb !== 4'b0000) $display("FAIL indep_step3: got %b expected 0000", m_stb);
        else n_pass++;
        #1;
        n_total++;
        if (s_rdy !== 1'b1) $display("FAIL indep_refill_rdy: got %b expected 1", s_rdy);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_pressure();
        m_rdy = 4'b0000;
        fill_frame(8'h50);
        for (int k = 0; k < N; k++) begin
            s_stb = 1'b1;
            s_dat = {2'(k), 8'hE0 + 8'(k)};
            #1;
            n_total++;
            if (s_rdy !== 1'b0) $display("FAIL bp_s_rdy[%0d]: got %b expected 0", k, s_rdy);
            else n_pass++;
            tick();
            n_total++;
            if (m_dat !== 32'h53525150) $display("FAIL bp_m_dat[%0d]: got %h expected 53525150", k, m_dat);
            else n_pass++;
        end
        s_stb = 1'b0;
        m_rdy = 4'b1111; tick(); m_rdy = 4'b0000;
        n_total++;
        if (m_stb !== 4'b0000) $display("FAIL bp_drained: got %b expected 0000", m_stb);
        else n_pass++;
    endtask

    task automatic test_n3_drop();
        m_rdy3 = 3'b000;
        s_stb3 = 1'b1; s_dat3 = {2'd3, 8'h99};
        #1;
        n_total++;
        if (s_rdy3 !== 1'b1) $display("FAIL n3_oob_rdy: got %b expected 1", s_rdy3);
        else n_pass++;
        tick();
        n_total++;
        if (m_stb3 !== 3'b000) $display("FAIL n3_oob_no_release: got %b expected 000", m_stb3);
        else n_pass++;
        s_dat3 = {2'd0, 8'h80}; tick();
        s_dat3 = {2'd0, 8'h8F};
        #1;
        n_total++;
        if (s_rdy3 !== 1'b0) $display("FAIL n3_dup_stall: got %b expected 0", s_rdy3);
        else n_pass++;
        s_dat3 = {2'd1, 8'h81}; tick();
        s_dat3 = {2'd3, 8'h98};
        #1;
        n_total++;
        if (s_rdy3 !== 1'b1) $display("FAIL n3_oob_rdy2: got %b expected 1", s_rdy3);
        else n_pass++;
        tick();
        n_total++;
        if (m_stb3 !== 3'b000) $display("FAIL n3_partial: got %b expected 000", m_stb3);
        else n_pass++;
        s_dat3 = {2'd2, 8'h82}; tick();
        s_stb3 = 1'b0;
        n_total++;
        if (m_stb3 !== 3'b111) $display("FAIL n3_release: got %b expected 111", m_stb3);
        else n_pass++;
        n_total++;
        if (m_dat3 !== 24'h828180) $display("FAIL n3_m_dat: got %h expected 828180", m_dat3);
        else n_pass++;
        m_rdy3 = 3'b111; tick(); m_rdy3 = 3'b000;
        n_total++;
        if (m_stb3 !== 3'b000) $display("FAIL n3_drained: got %b expected 000", m_stb3);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        m_rdy = 4'b0000;
        fill_frame(8'h60);
        m_rdy = 4'b1010; tick(); m_rdy = 4'b0000;
        n_total++;
        if (m_stb !== 4'b0101) $display("FAIL areset_pend: got %b expected 0101", m_stb);
        else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        n_total++;
        if (m_stb !== 4'b0000) $display("FAIL areset_m_stb: got %b expected 0000", m_stb);
        else n_pass++;
        n_total++;
        if (m_dat !== 32'h0) $display("FAIL areset_m_dat: got %h expected 00000000", m_dat);
        else n_pass++;
        #1;
        rst = 1'b1;
        s_stb = 1'b0; s_dat = {2'd0, 8'h70};
        #1;
        n_total++;
        if (s_rdy !== 1'b1) $display("FAIL areset_s_rdy: got %b expected 1", s_rdy);
        else n_pass++;
        tick();
        fill_frame(8'h70);
        n_total++;
        if (m_stb !== 4'b1111) $display("FAIL areset_new_release: got %b expected 1111", m_stb);
        else n_pass++;
        n_total++;
        if (m_dat !== 32'h73727170) $display("FAIL areset_new_dat: got %h expected 73727170", m_dat);
        else n_pass++;
        m_rdy = 4'b1111; tick(); m_rdy = 4'b0000;
    endtask

    task automatic test_random();
        logic [N-1:0]   e_stb;
        logic [N*W-1:0] e_dat;
        bit             e_rdy;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            s_stb = ($urandom_range(0, 3) != 0);
            s_dat = {2'($urandom_range(0, 3)), 8'($urandom)};
            m_rdy = 4'($urandom);
            #1;
            e_rdy = exp_rdy();
            e_stb = exp_stb();
            e_dat = exp_dat();
            n_total++;
            if (s_rdy !== e_rdy) $display("FAIL rand_s_rdy@%0d: got %b expected %b", c, s_rdy, e_rdy);
            else n_pass++;
            n_total++;
            if (m_stb !== e_stb) $display("FAIL rand_m_stb@%0d: got %b expected %b", c, m_stb, e_stb);
            else n_pass++;
            n_total++;
            if (m_dat !== e_dat) $display("FAIL rand_m_dat@%0d: got %h expected %h", c, m_dat, e_dat);
            else n_pass++;
            @(posedge clk);
            model_edge();
            #1;
        end
        s_stb = 1'b0;
        m_rdy = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_dup();
        test_independent_drain();
        test_back_pressure();
        test_n3_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_scatter
`default_nettype wire

// File: doc/scatter.md
Name: scatter

Overview:
- Inverse of the gather/reorder path: consumes one tagged stream of {index, data} words and distributes each word to output port `index`.
- Words are collected per frame. A frame is one word for every index 0..N-1, in any arrival order.
- All N output ports are released together once the frame is complete. Each port then drains on its own handshake.
- Sits downstream of the ordered tagged stream and feeds N independent per-lane consumers.

Parameters:
- W, 8, data width per word.
- N, 2, number of output ports and frame length. N must be at least 2. AW = $clog2(N).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_stb  in  1  input word valid.
- s_dat  in  AW+W  input word: {index[AW-1:0], data[W-1:0]}, index in the MSBs.
- s_rdy  out  1  input accepted when s_stb & s_rdy.
- m_stb  out  N  per-port valid.
- m_dat  out  N*W  per-port data; port i occupies bits [i*W +: W].
- m_rdy  in  N  per-port ready.

Behaviour:
- State: FILL or DRAIN. Per-slot registers: slot[i] (W bits), full[i], pend[i].
- Reset (rst low, asynchronous): state=FILL, full=0, pend=0, slot[*]=0. Hence m_stb=0 and m_dat=0. s_rdy follows its FILL equation once rst is released.
- FILL:
  - s_rdy = (index >= N) | ~full[index]. This is combinational from s_dat, so it may depend on s_dat.
  - On accept with index < N: slot[index] <= data and full[index] <= 1.
  - On accept with index >= N (only possible when N is not a power of two): the word is consumed and discarded. No state changes.
  - Duplicate index within a frame: s_rdy stays low. The word stalls until the next FILL, then lands in the next frame.
  - m_stb = 0 throughout FILL.
- FILL -> DRAIN: on the cycle where full would become all-ones, including the accepting cycle. Next cycle: state=DRAIN, pend=all-ones.
  - Latency: last word accepted at edge t, all m_stb high after edge t.
- DRAIN:
  - s_rdy = 0.
  - m_stb = pend. m_dat[i] = slot[i], held stable while pend[i]=1.
  - Port handshake (m_stb[i] & m_rdy[i]): pend[i] <= 0 and full[i] <= 0.
  - Ports complete in any order and in the same cycle independently. A port that is not ready never blocks another port.
- DRAIN -> FILL: when pend becomes zero, including when several ports handshake in the same cycle. s_rdy can be high from the following cycle.
  - No overlap: input is never accepted in a cycle with any m_stb high.
- m_rdy high while m_stb is low has no effect. s_stb is ignored in DRAIN.
- Asserting reset mid-frame or mid-drain discards all buffered words. Outputs drop asynchronously.
- m_stb and m_dat come directly from registers. s_rdy is the only combinational output.

Decomposition:
- Shared include: state encoding (FILL=0, DRAIN=1) and the AW width expression, kept alongside the gather-side constants so both ends agree on the tag layout.
- One natural sub-module: demultiplex #(W, N). It decodes index into a one-hot slot write-enable and range check, and is the counterpart of the gather-side multiplex.
- The FSM, full/pend bookkeeping and slot registers stay in scatter.

Test Plan (W=8, N=4 unless noted):
- In-order frame: send {0,0x10},{1,0x11},{2,0x12},{3,0x13}, with m_rdy=1111 held. Required: m_stb=1111 exactly one cycle after the 4th accept, m_dat=0x13121110, m_stb=0000 the next cycle, s_rdy high the cycle after that.
- Out-of-order plus duplicate: send idx 2,0,2(0xAA),3,1, with m_rdy=0 during fill. Required: the second idx 2 stalls with s_rdy=0. Frame releases with slot2 = the first idx-2 value. After draining, 0xAA is accepted as slot2 of the next frame.
- Independent drain: full frame, m_rdy pattern 0001, then 1000, then 0110. Required: pend goes 1110 -> 0110 -> 0000, other ports' m_dat stays unchanged, and no s_rdy during DRAIN.
- Back-pressure on input: s_stb=1 continuously while in DRAIN. Required: s_rdy=0 and no slot is overwritten.
- N=3, index 3 arrives: s_rdy=1, word dropped, full unchanged. The frame completes only after indices 0..2 arrive.
- Async reset: pull rst low mid-DRAIN with pend=0101, off the clock edge. Required: m_stb=0 and m_dat=0 immediately. After release, s_rdy is high in FILL and a new frame behaves normally.
